// File: rtl/mac_fp4_dot_seq.sv
// ============================================================================
// mac_fp4_dot_seq
//
// Purpose:
//   Job sequencer for a row of N_MAC fp4 (e2m1) MAC units that share one
//   operand buffer. A job is a base address plus a length K. The sequencer
//   clears the accumulators, streams K operand pairs out of the buffer into
//   the MAC row, waits for the MAC pipeline to drain, captures every
//   accumulator into a result register and offers it on a valid/ready
//   handshake. A one-cycle done pulse follows the handshake.
//
// Optional feature (compile-time macro FP4_SEQ_RELU_EN):
//   When defined, every ACC_WIDTH lane whose sign bit is set is replaced by
//   zero as it is captured. Non-negative lanes pass unchanged. Timing is the
//   same in both builds.
//
// Ports:
//   clk           clock
//   reset         synchronous, active-high reset
//   i_start       job request, only looked at while idle
//   i_k_len       number of operand pairs, sampled with i_start
//   i_base_addr   first operand address, sampled with i_start
//   o_busy        high whenever the sequencer is not idle
//   o_rd_en       operand buffer read strobe (buffer read latency 1 cycle)
//   o_rd_addr     operand buffer address, wraps modulo 2^ADDR_W
//   o_mac_clr     clears MAC operand registers and accumulators
//   o_op_load     MAC operand-register load enable (o_rd_en delayed 1)
//   o_acc_en      MAC accumulator enable (o_op_load delayed 1)
//   i_mac_acc_in  concatenated accumulators, MAC i at [i*ACC_WIDTH +: ACC_WIDTH]
//   o_res_valid   result register holds a job result
//   i_res_ready   consumer accepts the result
//   o_res_data    captured results
//   o_done        one-cycle pulse on the cycle after the result handshake
// ============================================================================
module mac_fp4_dot_seq #(
    parameter int N_MAC     = 8,
    parameter int ACC_WIDTH = 23,
    parameter int K_W       = 10,
    parameter int ADDR_W    = 10,
    parameter int ACC_LAT   = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_start,
    input  logic [K_W-1:0]               i_k_len,
    input  logic [ADDR_W-1:0]            i_base_addr,
    output logic                         o_busy,
    output logic                         o_rd_en,
    output logic [ADDR_W-1:0]            o_rd_addr,
    output logic                         o_mac_clr,
    output logic                         o_op_load,
    output logic                         o_acc_en,
    input  logic [N_MAC*ACC_WIDTH-1:0]   i_mac_acc_in,
    output logic                         o_res_valid,
    input  logic                         i_res_ready,
    output logic [N_MAC*ACC_WIDTH-1:0]   o_res_data,
    output logic                         o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_WAIT,
        S_OUT
    } state_t;

    // The drain wait covers the operand-register stage, the accumulate stage
    // and the accumulator's own visibility latency.
    localparam int             WAIT_CYCLES = 2 + ACC_LAT;
    localparam logic [2:0]     WAIT_LAST   = 3'(WAIT_CYCLES - 1);

    state_t                        r_state;
    logic [K_W-1:0]                r_k_len;
    logic [ADDR_W-1:0]             r_base;
    logic [K_W-1:0]                r_stream_cnt;
    logic [2:0]                    r_wait_cnt;
    logic                          r_rd_en;
    logic [ADDR_W-1:0]             r_rd_addr;
    logic                          r_mac_clr;
    logic                          r_op_load;
    logic                          r_acc_en;
    logic                          r_res_valid;
    logic [N_MAC*ACC_WIDTH-1:0]    r_res_data;
    logic                          r_done;

    logic [N_MAC*ACC_WIDTH-1:0]    w_capture;
    logic                          w_stream_last;

    // Value loaded into the result register at the end of the drain wait.
`ifdef FP4_SEQ_RELU_EN
    always_comb begin
        w_capture = i_mac_acc_in;
        for (int i = 0; i < N_MAC; i++) begin
            if (i_mac_acc_in[i*ACC_WIDTH + ACC_WIDTH - 1]) begin
                w_capture[i*ACC_WIDTH +: ACC_WIDTH] = '0;
            end
        end
    end
`else
    assign w_capture = i_mac_acc_in;
`endif

    // k_len is never zero in STREAM (CLEAR bypasses it), so k_len-1 is safe.
    assign w_stream_last = (r_stream_cnt == (r_k_len - K_W'(1)));

    // Single sequencer process. op_load/acc_en are plain delay stages of
    // rd_en that run regardless of state, so the tail of a stream keeps
    // shifting through them while the FSM sits in WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_k_len      <= '0;
            r_base       <= '0;
            r_stream_cnt <= '0;
            r_wait_cnt   <= '0;
            r_rd_en      <= 1'b0;
            r_rd_addr    <= '0;
            r_mac_clr    <= 1'b0;
            r_op_load    <= 1'b0;
            r_acc_en     <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            r_done       <= 1'b0;
        end else begin
            r_op_load <= r_rd_en;
            r_acc_en  <= r_op_load;
            r_mac_clr <= 1'b0;
            r_done    <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_k_len   <= i_k_len;
                        r_base    <= i_base_addr;
                        r_mac_clr <= 1'b1;
                        r_state   <= S_CLEAR;
                    end
                end

                // An empty job has nothing to stream or drain; its result is
                // defined as all zeros rather than whatever the MACs hold.
                S_CLEAR: begin
                    if (r_k_len == '0) begin
                        r_res_data  <= '0;
                        r_res_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end else begin
                        r_rd_en      <= 1'b1;
                        r_rd_addr    <= r_base;
                        r_stream_cnt <= '0;
                        r_state      <= S_STREAM;
                    end
                end

                // Address increments wrap silently at 2^ADDR_W.
                S_STREAM: begin
                    if (w_stream_last) begin
                        r_rd_en    <= 1'b0;
                        r_wait_cnt <= '0;
                        r_state    <= S_WAIT;
                    end else begin
                        r_stream_cnt <= r_stream_cnt + K_W'(1);
                        r_rd_addr    <= r_rd_addr + ADDR_W'(1);
                    end
                end

                S_WAIT: begin
                    if (r_wait_cnt == WAIT_LAST) begin
                        r_res_data  <= w_capture;
                        r_res_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 3'd1;
                    end
                end

                S_OUT: begin
                    if (i_res_ready) begin
                        r_res_valid <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy      = (r_state != S_IDLE);
    assign o_rd_en     = r_rd_en;
    assign o_rd_addr   = r_rd_addr;
    assign o_mac_clr   = r_mac_clr;
    assign o_op_load   = r_op_load;
    assign o_acc_en    = r_acc_en;
    assign o_res_valid = r_res_valid;
    assign o_res_data  = r_res_data;
    assign o_done      = r_done;

endmodule

// File: tb/tb_mac_fp4_dot_seq.sv
// ============================================================================
// tb_mac_fp4_dot_seq
//
// Self-checking bench for mac_fp4_dot_seq. The bench plays the operand
// buffer and a simple integer MAC row (each lane accumulates the operand it
// reads), so the captured result of a job is the per-lane sum of the operand
// words at base..base+K-1 modulo the buffer size. Expected results and the
// expected control waveform of each job are queued when the job is issued;
// a separate monitor compares them against the DUT on every falling edge.
// ============================================================================
module tb_mac_fp4_dot_seq;

    localparam int N_MAC = 8;
    localparam int AW    = 23;
    localparam int KW    = 10;
    localparam int ADW   = 10;
    localparam int LAT   = 1;
    localparam int DW    = N_MAC * AW;
    localparam int DEPTH = 1 << ADW;
    localparam int MAXC  = 20000;
    localparam int DIDX  = (LAT >= 2) ? LAT - 2 : 0;

    typedef struct {
        logic [DW-1:0] data;
        int            validCycle;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            iStart;
    logic [KW-1:0]   iKLen;
    logic [ADW-1:0]  iBaseAddr;
    logic            oBusy;
    logic            oRdEn;
    logic [ADW-1:0]  oRdAddr;
    logic            oMacClr;
    logic            oOpLoad;
    logic            oAccEn;
    logic [DW-1:0]   macAccIn;
    logic            oResValid;
    logic            iResReady;
    logic [DW-1:0]   oResData;
    logic            oDone;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Operand buffer contents, one signed word per lane per address.
    int mem [N_MAC][DEPTH];

    // Behavioural MAC row driven by the DUT's control strobes.
    logic [AW-1:0] rdData [N_MAC];
    logic [AW-1:0] opReg  [N_MAC];
    logic [AW-1:0] acc    [N_MAC];
    logic [AW-1:0] dly    [N_MAC][4];
    logic [DW-1:0] modelOut;
    bit            scramble = 1'b0;
    logic [DW-1:0] scrambleVal = '0;

    // Expected control waveform indexed by absolute cycle number.
    bit expClr  [MAXC];
    bit expRd   [MAXC];
    bit expOp   [MAXC];
    bit expAcc  [MAXC];
    bit expBusy [MAXC];
    int expAddr [MAXC];

    exp_t sbq[$];
    bit   monitorOn = 1'b0;
    bit   inValid   = 1'b0;
    bit   doneDue   = 1'b0;
    exp_t cur;

    mac_fp4_dot_seq #(
        .N_MAC    (N_MAC),
        .ACC_WIDTH(AW),
        .K_W      (KW),
        .ADDR_W   (ADW),
        .ACC_LAT  (LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_start     (iStart),
        .i_k_len     (iKLen),
        .i_base_addr (iBaseAddr),
        .o_busy      (oBusy),
        .o_rd_en     (oRdEn),
        .o_rd_addr   (oRdAddr),
        .o_mac_clr   (oMacClr),
        .o_op_load   (oOpLoad),
        .o_acc_en    (oAccEn),
        .i_mac_acc_in(macAccIn),
        .o_res_valid (oResValid),
        .i_res_ready (iResReady),
        .o_res_data  (oResData),
        .o_done      (oDone)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Operand buffer with one-cycle read latency feeding the MAC lanes.
    always @(posedge clk) begin
        for (int l = 0; l < N_MAC; l++) begin
            if (oRdEn) rdData[l] <= AW'(mem[l][oRdAddr]);
            if (oMacClr) begin
                opReg[l] <= '0;
                acc[l]   <= '0;
            end else begin
                if (oOpLoad) opReg[l] <= rdData[l];
                if (oAccEn)  acc[l]   <= acc[l] + opReg[l];
            end
            dly[l][0] <= acc[l];
            for (int j = 1; j < 4; j++) dly[l][j] <= dly[l][j-1];
        end
    end

    always_comb begin
        modelOut = '0;
        for (int l = 0; l < N_MAC; l++) begin
            if (LAT == 1) modelOut[l*AW +: AW] = acc[l];
            else          modelOut[l*AW +: AW] = dly[l][DIDX];
        end
    end

    assign macAccIn = scramble ? scrambleVal : modelOut;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected result straight from the job definition: per-lane sum of the
    // K operand words starting at base, addresses wrapping at the buffer size.
    function automatic logic [DW-1:0] expectedResult(input int k, input int base);
        logic [DW-1:0] r;
        logic [AW-1:0] lane;
        int            sum;
        r = '0;
        for (int l = 0; l < N_MAC; l++) begin
            sum = 0;
            for (int i = 0; i < k; i++) sum += mem[l][(base + i) % DEPTH];
            lane = AW'(sum);
`ifdef FP4_SEQ_RELU_EN
            if (lane[AW-1]) lane = '0;
`endif
            r[l*AW +: AW] = lane;
        end
        return r;
    endfunction

    // Expected strobes of a job accepted in cycle c, up to cycle lastCyc.
    task automatic planControls(input int c, input int k, input int base, input int lastCyc);
        int vc;
        vc = (k == 0) ? c + 2 : c + k + 4 + LAT;
        if (c + 1 <= lastCyc) expClr[c+1] = 1'b1;
        for (int t = c + 1; t < vc && t <= lastCyc; t++) expBusy[t] = 1'b1;
        for (int j = 0; j < k; j++) begin
            if (c + 2 + j <= lastCyc) begin
                expRd[c+2+j]   = 1'b1;
                expAddr[c+2+j] = (base + j) % DEPTH;
            end
            if (c + 3 + j <= lastCyc) expOp[c+3+j]  = 1'b1;
            if (c + 4 + j <= lastCyc) expAcc[c+4+j] = 1'b1;
        end
    endtask

    // Issue one job, let the result sit unaccepted for holdCycles cycles
    // (optionally pulsing start and scrambling the MAC outputs meanwhile),
    // then accept it.
    task automatic applyStimulus(input int k, input int base, input int holdCycles, input bit pulseStart);
        exp_t e;
        int   c;
        int   n;
        c = cyc;
        iStart    = 1'b1;
        iKLen     = KW'(k);
        iBaseAddr = ADW'(base);
        e.data       = expectedResult(k, base);
        e.validCycle = (k == 0) ? c + 2 : c + k + 4 + LAT;
        sbq.push_back(e);
        planControls(c, k, base, MAXC - 1);
        step();
        iStart    = 1'b0;
        iKLen     = KW'($urandom);
        iBaseAddr = ADW'($urandom);
        n = 0;
        while (!oResValid && n < 3000) begin
            iResReady = 1'($urandom % 2);
            step();
            n++;
        end
        if (!oResValid) begin
            checkOutput("valid_timeout", 0, 1);
            return;
        end
        iResReady = 1'b0;
        for (int h = 0; h < holdCycles; h++) begin
            iStart = pulseStart && (h == 1);
            iKLen  = KW'($urandom_range(1, 20));
            scramble = 1'b1;
            for (int b = 0; b < DW; b++) scrambleVal[b] = 1'($urandom % 2);
            step();
        end
        iStart    = 1'b0;
        iResReady = 1'b1;
        step();
        iResReady = 1'b0;
        scramble  = 1'b0;
        step();
    endtask

    // Start a k=8 job and assert reset during its second streaming cycle.
    task automatic resetMidJob(input int base);
        int c;
        c = cyc;
        iStart    = 1'b1;
        iKLen     = KW'(8);
        iBaseAddr = ADW'(base);
        planControls(c, 8, base, c + 3);
        step();
        iStart = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("abort_busy", oBusy, 0);
        checkOutput("abort_rd_en", oRdEn, 0);
        checkOutput("abort_rd_addr", oRdAddr, 0);
        checkOutput("abort_op_load", oOpLoad, 0);
        checkOutput("abort_acc_en", oAccEn, 0);
        checkOutput("abort_mac_clr", oMacClr, 0);
        checkOutput("abort_res_valid", oResValid, 0);
        step();
    endtask

    // Monitor: control strobes against the planned waveform, results against
    // the scoreboard, done against the observed handshake.
    always @(negedge clk) begin
        if (monitorOn) begin
            checkOutput("mac_clr", oMacClr, expClr[cyc]);
            checkOutput("rd_en", oRdEn, expRd[cyc]);
            checkOutput("op_load", oOpLoad, expOp[cyc]);
            checkOutput("acc_en", oAccEn, expAcc[cyc]);
            if (expRd[cyc]) checkOutput("rd_addr", oRdAddr, expAddr[cyc]);
            if (expBusy[cyc]) checkOutput("busy_in_job", oBusy, 1);
            checkOutput("done", oDone, doneDue);
            if (doneDue) checkOutput("busy_after_done", oBusy, 0);
            doneDue = 1'b0;
            if (oResValid) begin
                if (!inValid) begin
                    if (sbq.size() == 0) begin
                        checkOutput("unexpected_valid", 1, 0);
                        cur.data       = oResData;
                        cur.validCycle = cyc;
                    end else begin
                        cur = sbq.pop_front();
                        checkOutput("valid_cycle", cyc, cur.validCycle);
                    end
                    inValid = 1'b1;
                end
                checks++;
                if (oResData !== cur.data) begin
                    failures++;
                    $display("[TB] FAIL res_data at cycle %0d: got %h expected %h", cyc, oResData, cur.data);
                end
                checkOutput("busy_in_out", oBusy, 1);
                if (iResReady) begin
                    doneDue = 1'b1;
                    inValid = 1'b0;
                end
            end else if (inValid) begin
                checkOutput("valid_dropped", 0, 1);
                inValid = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int l = 0; l < N_MAC; l++)
            for (int a = 0; a < DEPTH; a++)
                mem[l][a] = int'($urandom_range(0, 200)) - 100;
        mem[0][500] = -5;
        mem[1][500] = 7;

        reset     = 1'b1;
        iStart    = 1'b0;
        iKLen     = '0;
        iBaseAddr = '0;
        iResReady = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        checkOutput("reset_busy", oBusy, 0);
        checkOutput("reset_rd_en", oRdEn, 0);
        checkOutput("reset_rd_addr", oRdAddr, 0);
        checkOutput("reset_mac_clr", oMacClr, 0);
        checkOutput("reset_op_load", oOpLoad, 0);
        checkOutput("reset_acc_en", oAccEn, 0);
        checkOutput("reset_res_valid", oResValid, 0);
        checkOutput("reset_res_data", longint'(|oResData), 0);
        checkOutput("reset_done", oDone, 0);
        monitorOn = 1'b1;
        step();

        applyStimulus(4, 10, 0, 1'b0);
        applyStimulus(4, 1022, 0, 1'b0);
        applyStimulus(0, 77, 0, 1'b0);
        applyStimulus(6, 300, 5, 1'b1);
        resetMidJob(40);
        applyStimulus(2, 40, 1, 1'b0);
        applyStimulus(1, 500, 0, 1'b0);

        for (int j = 0; j < 25; j++) begin
            int k;
            k = ($urandom % 7 == 0) ? 0 : int'($urandom_range(1, 24));
            applyStimulus(k, int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 3)), 1'($urandom % 2));
        end

        repeat (4) step();
        checkOutput("scoreboard_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_fp4_dot_seq.md
Name: mac_fp4_dot_seq

Overview:
Sequencer for a row of N_MAC fp4 (e2m1) MAC units that share one operand buffer. It accepts a dot-product job (base address, length K), streams K operand pairs from the buffer into the MACs, and clears the accumulators before the job. After the pipeline drains it captures all accumulator values into a result register and presents them through a valid/ready handshake. It sits between the job scheduler/host and the MAC row plus its operand SRAM.

Parameters:
N_MAC, 8, number of MAC units in the row
ACC_WIDTH, 23, accumulator width per MAC (signed two's complement)
K_W, 10, width of job length k_len
ADDR_W, 10, operand buffer address width
ACC_LAT, 1, cycles from the acc_en cycle until the accumulated value is visible on mac_acc_in (allowed range 1..4)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  job request; sampled only in IDLE
k_len  in  K_W  number of operand pairs; sampled with start
base_addr  in  ADDR_W  first operand address; sampled with start
busy  out  1  high whenever state != IDLE
rd_en  out  1  operand buffer read strobe; buffer read latency is fixed at 1 cycle
rd_addr  out  ADDR_W  operand buffer address
mac_clr  out  1  synchronous clear of MAC operand registers and accumulators
op_load  out  1  MAC operand-register load enable
acc_en  out  1  MAC accumulator enable
mac_acc_in  in  N_MAC*ACC_WIDTH  concatenated MAC outputs; MAC i occupies bits [i*ACC_WIDTH +: ACC_WIDTH]
res_valid  out  1  result register holds a valid job result
res_ready  in  1  consumer accepts the result
res_data  out  N_MAC*ACC_WIDTH  captured results
done  out  1  one-cycle pulse on the cycle after the result handshake

Behaviour:
- Reset values: all control outputs 0, res_data 0, rd_addr 0, state IDLE, counters 0.
- Reset asserted mid-job aborts the job: next cycle is IDLE with reset values. The accumulator contents are not cleared by the sequencer.
- States: IDLE, CLEAR, STREAM, WAIT, OUT.
- IDLE: when start=1, latch k_len and base_addr and go to CLEAR.
- CLEAR: lasts exactly 1 cycle with mac_clr=1. If the latched k_len==0, load res_data with all zeros and go to OUT. Otherwise go to STREAM.
- STREAM: lasts exactly k_len cycles with rd_en=1. On cycle i (0-based), rd_addr = (base_addr + i) mod 2^ADDR_W, so addresses wrap silently.
- op_load equals rd_en delayed by 1 cycle. acc_en equals op_load delayed by 1 cycle. Both delays are registered and continue into WAIT.
- WAIT: lasts 2+ACC_LAT cycles, counted from the first cycle after STREAM. On the clock edge ending the last WAIT cycle, res_data <= mac_acc_in, then go to OUT.
- OUT: res_valid=1 and res_data is held stable. When res_ready=1, go to IDLE, and done=1 on the following cycle.
- Latency for k_len=K>0: start accepted in cycle 0; CLEAR in cycle 1; STREAM in cycles 2..K+1; res_valid first high in cycle K+4+ACC_LAT.
- start outside IDLE is ignored; there is no queueing.
- res_ready outside OUT is ignored.
- res_valid is never combinationally dependent on res_ready.
- Widths: the sequencer performs no arithmetic on accumulator data except the optional clamp below. Overflow of the accumulators is the datapath's concern.

Optional Feature:
FP4_SEQ_RELU_EN: when defined, each ACC_WIDTH lane is replaced by 0 at capture if its sign bit is 1; non-negative lanes pass unchanged. When undefined, lanes are captured unmodified. Timing is identical in both builds.

Test Plan:
- reset, then start with k_len=4, base_addr=10, res_ready=1 → mac_clr in cycle 1; rd_addr 10,11,12,13 in cycles 2..5; op_load in cycles 3..6; acc_en in cycles 4..7; res_valid in cycle 9 (ACC_LAT=1); done in cycle 10.
- base_addr=1022, k_len=4, ADDR_W=10 → rd_addr sequence 1022, 1023, 0, 1.
- k_len=0 → CLEAR, then OUT with res_data=0; no rd_en/op_load/acc_en pulses; mac_clr still pulses once.
- res_ready held 0 for 5 cycles in OUT, with mac_acc_in changing and start pulsed → res_valid and res_data stay stable and start is ignored; handshake on res_ready=1, then done.
- reset asserted in the second STREAM cycle of a k_len=8 job → next cycle busy=0 and all outputs 0; a new job with k_len=2 then completes normally.
- FP4_SEQ_RELU_EN defined, lane0 = -5, lane1 = +7 at capture → res_data lane0=0, lane1=7. With the macro undefined → lane0 = 0x7FFFFB (−5 in 23-bit two's complement), lane1=7.
